// File: rtl/nano_pkg.sv
// Shared definitions for the nano_riscv core, its instruction memory and benches.
// Holds the canonical NOP and the boot loader state encoding.
package nano_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_RUN
    } imem_state_t;

endpackage

// File: rtl/nano_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Read and write addresses are independent; read-during-write is never exercised.
module nano_sdp_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto block RAM; contents survive i_rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/nano_imem.sv
// Instruction memory with byte-stream boot loader for nano_riscv.
// Holds the core in reset until a complete program has been packed into memory.
module nano_imem
    import nano_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    input  logic [31:0] i_pc,
    output logic [31:0] o_inst,
    output logic        o_core_rst,
    output logic        o_loaded,
    output logic        o_err
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    imem_state_t state, next_state;

    logic [15:0]       len;
    logic [15:0]       wptr;
    logic [1:0]        byte_cnt;
    logic [23:0]       hold;
    logic              err;
    logic              run_q;
    logic              accept;
    logic              word_done;
    logic              last_word;
    logic              in_range;
    logic [15:0]       len_full;
    logic              we;
    logic [31:0]       rdata;
    logic              unused_pc;

    assign o_byte_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
    assign o_loaded     = (state == ST_RUN);
    assign o_core_rst   = !o_loaded;
    assign o_err        = err;

    // A restart pulse wins over a byte offered in the same cycle.
    assign accept    = i_byte_valid && o_byte_ready && !i_load_start;
    assign word_done = accept && (state == ST_DATA) && (byte_cnt == 2'd3);
    assign last_word = ({1'b0, wptr} + 17'd1) == {1'b0, len};
    assign in_range  = {1'b0, wptr} < DEPTH_L;
    assign len_full  = {i_byte, len[7:0]};
    assign we        = word_done && in_range;
    assign unused_pc = ^i_pc[31:ADDR_W];

    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        if (i_load_start) begin
            next_state = ST_LEN_LO;
        end else if (accept) begin
            case (state)
                ST_LEN_LO: next_state = ST_LEN_HI;
                ST_LEN_HI: next_state = (len_full == 16'd0) ? ST_RUN : ST_DATA;
                ST_DATA:   if ((byte_cnt == 2'd3) && last_word) next_state = ST_RUN;
                default:   next_state = state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len      <= '0;
            wptr     <= '0;
            byte_cnt <= '0;
            hold     <= '0;
            err      <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            run_q <= (state == ST_RUN) && !i_load_start;
            if (i_load_start) begin
                wptr     <= '0;
                byte_cnt <= '0;
                err      <= 1'b0;
            end else if (accept) begin
                case (state)
                    ST_LEN_LO: len[7:0]  <= i_byte;
                    ST_LEN_HI: len[15:8] <= i_byte;
                    ST_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        hold     <= {i_byte, hold[23:8]};
                        // Words past the end are counted but dropped; wptr never wraps.
                        if (byte_cnt == 2'd3) begin
                            wptr <= wptr + 16'd1;
                            if (!in_range) err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    nano_sdp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (i_clk),
        .we    (we),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata ({i_byte, hold}),
        .raddr (i_pc[ADDR_W-1:0]),
        .rdata (rdata)
    );

    assign o_inst = run_q ? rdata : NOP_INST;

endmodule

// File: tb/tb_nano_imem.sv
// Scoreboard bench for nano_imem: a full-size and a DEPTH=4 instance share stimulus;
// expectations are queued by cycle and compared by a negedge monitor.
module tb_nano_imem;
    import nano_pkg::*;

    typedef enum int {K_INST, K_ERR, K_RST, K_LOADED, K_READY} kind_t;

    typedef struct {
        int          cyc;
        int          dut;
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_load_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic [31:0] i_pc = 32'h0;

    logic        ready_b, core_rst_b, loaded_b, err_b;
    logic        ready_s, core_rst_s, loaded_s, err_s;
    logic [31:0] inst_b, inst_s;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [31:0] ovf_words [5] = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0,
                                   32'hDEAD_BEEF, 32'h55AA_33CC};

    nano_imem u_big (
        .i_clk(i_clk), .i_rst(i_rst), .i_load_start(i_load_start),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(ready_b),
        .i_pc(i_pc), .o_inst(inst_b), .o_core_rst(core_rst_b),
        .o_loaded(loaded_b), .o_err(err_b)
    );

    nano_imem #(.DEPTH(4), .ADDR_W(2)) u_small (
        .i_clk(i_clk), .i_rst(i_rst), .i_load_start(i_load_start),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(ready_s),
        .i_pc(i_pc), .o_inst(inst_s), .o_core_rst(core_rst_s),
        .o_loaded(loaded_s), .o_err(err_s)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int dut, input kind_t k);
        case (k)
            K_INST:   return (dut == 0) ? inst_b : inst_s;
            K_ERR:    return {31'b0, (dut == 0) ? err_b : err_s};
            K_RST:    return {31'b0, (dut == 0) ? core_rst_b : core_rst_s};
            K_LOADED: return {31'b0, (dut == 0) ? loaded_b : loaded_s};
            default:  return {31'b0, (dut == 0) ? ready_b : ready_s};
        endcase
    endfunction

    // Monitor: pops every expectation due at this cycle and compares it.
    always @(negedge i_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) check({e.name, "_stale"}, 32'd1, 32'd0);
            else check($sformatf("%s_dut%0d", e.name, e.dut), actual(e.dut, e.kind), e.exp);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Expectation for the state visible in the current cycle (sampled at its negedge).
    task automatic exp_at(input int dut, input kind_t k, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc; e.dut = dut; e.kind = k; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp_both(input kind_t k, input logic [31:0] v, input string name);
        exp_at(0, k, v, name);
        exp_at(1, k, v, name);
    endtask

    task automatic pulse_start();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit slow);
        i_byte_valid = 1'b1;
        i_byte = b;
        tick();
        i_byte_valid = 1'b0;
        if (slow) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit slow);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0], slow);
        end
    endtask

    task automatic read_pc(input int pc, input int dut, input logic [31:0] v, input string name);
        i_pc = pc;
        tick();
        exp_at(dut, K_INST, v, name);
    endtask

    // Basic program: N=2, 0x00100093, 0x00200113.
    task automatic load_basic(input bit slow);
        logic [7:0] bytes [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                                   8'h13, 8'h01, 8'h20, 8'h00};
        for (int i = 0; i < 10; i++) begin
            send_byte(bytes[i], slow);
            if (i == 8) exp_both(K_LOADED, 32'd0, "basic_not_done");
            if (i == 4 && slow) exp_both(K_READY, 32'd1, "slow_ready");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick();
        tick();
        exp_both(K_RST, 32'd1, "rst_core_rst");
        exp_both(K_INST, NOP_INST, "rst_inst");
        exp_both(K_READY, 32'd0, "rst_ready");
        exp_both(K_ERR, 32'd0, "rst_err");
        i_rst = 1'b0;
        tick();
        exp_both(K_LOADED, 32'd0, "idle_loaded");

        // Basic load, bytes every cycle
        pulse_start();
        exp_both(K_READY, 32'd1, "start_ready");
        exp_both(K_RST, 32'd1, "start_core_rst");
        load_basic(1'b0);
        exp_both(K_LOADED, 32'd1, "basic_loaded");
        exp_both(K_RST, 32'd0, "basic_core_rst");
        exp_both(K_READY, 32'd0, "run_ready");
        exp_both(K_INST, NOP_INST, "first_run_nop");
        read_pc(0, 0, 32'h0010_0093, "basic_pc0");
        read_pc(1, 0, 32'h0020_0113, "basic_pc1");

        // N=0 keeps previous contents
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_both(K_LOADED, 32'd1, "n0_loaded");
        read_pc(1, 0, 32'h0020_0113, "n0_pc1");
        read_pc(0, 1, 32'h0010_0093, "n0_pc0_small");

        // Reload from RUN
        pulse_start();
        exp_both(K_RST, 32'd1, "reload_core_rst");
        exp_both(K_LOADED, 32'd0, "reload_loaded");
        tick();
        exp_both(K_INST, NOP_INST, "reload_nop");

        // Overflow: N=5 into the DEPTH=4 instance
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_word(ovf_words[i], 1'b0);
            if (i == 3) exp_at(1, K_ERR, 32'd0, "ovf_err_before");
        end
        exp_at(1, K_ERR, 32'd1, "ovf_err_small");
        exp_at(0, K_ERR, 32'd0, "ovf_err_big");
        exp_both(K_LOADED, 32'd1, "ovf_loaded");
        for (int i = 0; i < 4; i++) read_pc(i, 1, ovf_words[i], $sformatf("ovf_pc%0d", i));
        read_pc(4, 1, ovf_words[0], "ovf_alias");
        read_pc(4, 0, ovf_words[4], "ovf_big_pc4");

        // Restart mid-load with a byte offered alongside the start pulse
        pulse_start();
        exp_at(1, K_ERR, 32'd0, "restart_err_clear");
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        i_load_start = 1'b1;
        i_byte_valid = 1'b1;
        i_byte = 8'hEE;
        tick();
        i_load_start = 1'b0;
        i_byte_valid = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'hCAFE_BABE, 1'b0);
        exp_both(K_LOADED, 32'd1, "restart_loaded");
        read_pc(0, 0, 32'hCAFE_BABE, "restart_pc0");
        read_pc(0, 1, 32'hCAFE_BABE, "restart_pc0_small");
        read_pc(1, 0, ovf_words[1], "restart_pc1_kept");

        // Backpressure: a byte every other cycle
        pulse_start();
        load_basic(1'b1);
        exp_both(K_LOADED, 32'd1, "slow_loaded");
        read_pc(0, 0, 32'h0010_0093, "slow_pc0");
        read_pc(1, 0, 32'h0020_0113, "slow_pc1");

        // Bytes in RUN are ignored
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        exp_both(K_LOADED, 32'd1, "run_ignore_loaded");
        read_pc(0, 0, 32'h0010_0093, "run_ignore_pc0");

        // Reset mid-load holds the core in reset
        pulse_start();
        send_byte(8'h01, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_both(K_RST, 32'd1, "midrst_core_rst");
        exp_both(K_READY, 32'd0, "midrst_ready");
        tick();
        tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
